// File: rtl/lcd_text_formatter.sv
// Snapshots a Mini-CPU result and streams it as a 2x16 ASCII screen image over valid/ready.
// Optional build macro LCD_FMT_ZERO_BLANK_EN blanks leading zero digits of the value.
module lcd_text_formatter #(
  parameter logic [7:0] PAD_CHAR = 8'h20,
  parameter logic [7:0] SEP_CHAR = 8'h3D
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  opcode,
  input  logic [3:0]  dest_reg,
  input  logic [15:0] result,
  input  logic        char_ready,
  output logic        char_valid,
  output logic [7:0]  char_data,
  output logic [4:0]  char_pos,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONVERT,
    S_EMIT
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [3:0]  r_opcode;
  logic [3:0]  r_dest;
  logic        r_neg;
  logic [35:0] r_dd;
  logic [4:0]  r_cnt;
  logic [4:0]  r_pos;
  logic [7:0]  r_char;
  logic        r_valid;
  logic        r_done;

  logic        w_accept;
  logic        w_last;
  logic [15:0] w_mag;
  logic [35:0] w_adj;
  logic [35:0] w_dd_step;
  logic [19:0] w_bcd;
  logic [4:0]  w_gen_pos;
  logic [2:0]  w_dsel;
  logic [3:0]  w_digit;
  logic        w_blank;
  logic [55:0] w_mnem;
  logic [7:0]  w_mnem_char;
  logic        w_tens;
  logic [3:0]  w_ones;
  logic [7:0]  w_char;

  assign w_accept  = r_valid & char_ready;
  assign w_last    = (r_pos == 5'd31);
  assign w_mag     = result[15] ? (~result + 16'd1) : result;
  assign w_bcd     = r_dd[35:16];

  // Character for the position that will be presented next: 0 on leaving CONVERT, pos+1 in EMIT.
  assign w_gen_pos = (r_state == S_EMIT) ? (r_pos + 5'd1) : 5'd0;
  assign w_dsel    = w_gen_pos[2:0] - 3'd2;

  // ---------------------------------------------------------------- FSM
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start) w_next = S_CONVERT;
      S_CONVERT: if (r_cnt == 5'd16) w_next = S_EMIT;
      S_EMIT:    if (w_accept && w_last) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- double dabble step
  always_comb begin
    w_adj = r_dd;
    for (int unsigned i = 0; i < 5; i++) begin
      if (r_dd[16 + 4*i +: 4] >= 4'd5)
        w_adj[16 + 4*i +: 4] = r_dd[16 + 4*i +: 4] + 4'd3;
    end
    w_dd_step = w_adj << 1;
  end

  // ---------------------------------------------------------------- character generation
  always_comb begin
    w_mnem = "-      ";
    case (r_opcode)
      4'd0:    w_mnem = "LOAD   ";
      4'd1:    w_mnem = "ADD    ";
      4'd2:    w_mnem = "ADDI   ";
      4'd3:    w_mnem = "SUB    ";
      4'd4:    w_mnem = "SUBI   ";
      4'd5:    w_mnem = "MUL    ";
      4'd6:    w_mnem = "CLEAR  ";
      4'd7:    w_mnem = "DISPLAY";
      default: w_mnem = "-      ";
    endcase
  end

  always_comb begin
    w_mnem_char = PAD_CHAR;
    case (w_gen_pos[2:0])
      3'd0:    w_mnem_char = w_mnem[55:48];
      3'd1:    w_mnem_char = w_mnem[47:40];
      3'd2:    w_mnem_char = w_mnem[39:32];
      3'd3:    w_mnem_char = w_mnem[31:24];
      3'd4:    w_mnem_char = w_mnem[23:16];
      3'd5:    w_mnem_char = w_mnem[15:8];
      3'd6:    w_mnem_char = w_mnem[7:0];
      default: w_mnem_char = PAD_CHAR;
    endcase
  end

  always_comb begin
    w_digit = 4'd0;
    case (w_dsel)
      3'd0:    w_digit = w_bcd[19:16];
      3'd1:    w_digit = w_bcd[15:12];
      3'd2:    w_digit = w_bcd[11:8];
      3'd3:    w_digit = w_bcd[7:4];
      3'd4:    w_digit = w_bcd[3:0];
      default: w_digit = 4'd0;
    endcase
  end

`ifdef LCD_FMT_ZERO_BLANK_EN
  // A digit is blanked only when it and every more significant digit are zero; the units digit never is.
  always_comb begin
    w_blank = 1'b0;
    case (w_gen_pos)
      5'd18:   w_blank = (w_bcd[19:16] == 4'd0);
      5'd19:   w_blank = (w_bcd[19:12] == 8'd0);
      5'd20:   w_blank = (w_bcd[19:8]  == 12'd0);
      5'd21:   w_blank = (w_bcd[19:4]  == 16'd0);
      default: w_blank = 1'b0;
    endcase
  end
`else
  assign w_blank = 1'b0;
`endif

  assign w_tens = (r_dest >= 4'd10);
  assign w_ones = w_tens ? (r_dest - 4'd10) : r_dest;

  always_comb begin
    w_char = PAD_CHAR;
    case (w_gen_pos) inside
      [5'd0:5'd6]:   w_char = w_mnem_char;
      5'd8:          w_char = 8'h52;
      5'd9:          w_char = {7'b0011000, w_tens};
      5'd10:         w_char = {4'h3, w_ones};
      5'd16:         w_char = SEP_CHAR;
      5'd17:         w_char = r_neg ? 8'h2D : 8'h2B;
      [5'd18:5'd22]: w_char = w_blank ? PAD_CHAR : {4'h3, w_digit};
      default:       w_char = PAD_CHAR;
    endcase
  end

  // ---------------------------------------------------------------- state and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_opcode <= '0;
      r_dest   <= '0;
      r_neg    <= 1'b0;
      r_dd     <= '0;
      r_cnt    <= '0;
      r_pos    <= '0;
      r_char   <= '0;
      r_valid  <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_opcode <= opcode;
            r_dest   <= dest_reg;
            r_neg    <= result[15];
            r_dd     <= {20'd0, w_mag};
            r_cnt    <= '0;
          end
        end
        S_CONVERT: begin
          if (r_cnt != 5'd16) begin
            r_dd  <= w_dd_step;
            r_cnt <= r_cnt + 5'd1;
          end else begin
            r_pos   <= '0;
            r_char  <= w_char;
            r_valid <= 1'b1;
          end
        end
        S_EMIT: begin
          if (w_accept) begin
            if (w_last) begin
              r_valid <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_pos  <= r_pos + 5'd1;
              r_char <= w_char;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign char_valid = r_valid;
  assign char_data  = r_char;
  assign char_pos   = r_pos;
  assign busy       = (r_state != S_IDLE);
  assign done       = r_done;

endmodule

// File: tb/tb_lcd_text_formatter.sv
// Directed, table-driven checks of the LCD text formatter screen image and handshake timing.
module tb_lcd_text_formatter;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  opcode;
  logic [3:0]  dest_reg;
  logic [15:0] result;
  logic        char_ready;
  logic        char_valid;
  logic [7:0]  char_data;
  logic [4:0]  char_pos;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;

  lcd_text_formatter #(.PAD_CHAR(8'h20), .SEP_CHAR(8'h3D)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .opcode     (opcode),
    .dest_reg   (dest_reg),
    .result     (result),
    .char_ready (char_ready),
    .char_valid (char_valid),
    .char_data  (char_data),
    .char_pos   (char_pos),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   op;
    logic [3:0]   d;
    logic [15:0]  res;
    logic [127:0] l1;
    logic [127:0] l2;
    logic [127:0] l2zb;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Drives one start (caller sits at a negedge) and collects the 32-character frame.
  task automatic run_frame(input logic [3:0] op, input logic [3:0] d, input logic [15:0] res,
                           input int mode, output logic [127:0] l1, output logic [127:0] l2,
                           output int ntx, output bit seq_ok, output int first_v,
                           output bit done_ok, output bit hold_ok);
    int cyc;
    int stall;
    logic [7:0] held;
    logic [7:0] buffer [32];
    opcode = op; dest_reg = d; result = res; start = 1'b1; char_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0; ntx = 0; seq_ok = 1'b1; first_v = -1; stall = 0; hold_ok = 1'b1; held = 8'h00;
    for (int i = 0; i < 32; i++) buffer[i] = 8'hxx;
    while (ntx < 32 && cyc < 300) begin
      if (char_valid && first_v < 0) first_v = cyc;
      if (done) seq_ok = 1'b0;
      if (mode == 1 && cyc == 3) begin
        start = 1'b1; opcode = 4'h5; dest_reg = 4'h7; result = 16'h1234;
      end
      if (mode == 1 && cyc == 4) start = 1'b0;
      if (mode == 1 && cyc == 5) chk("busy_mid_convert", busy, 1);
      char_ready = 1'b1;
      if (mode == 2 && char_valid && char_pos == 5'd9 && stall < 5) begin
        if (stall == 0) held = char_data;
        else if (char_data !== held) hold_ok = 1'b0;
        char_ready = 1'b0;
        stall++;
      end
      if (char_valid && char_ready) begin
        if (char_pos !== 5'(ntx)) seq_ok = 1'b0;
        buffer[ntx] = char_data;
        ntx++;
      end
      @(negedge clk);
      cyc++;
    end
    done_ok = (done === 1'b1) && (char_valid === 1'b0) && (busy === 1'b0);
    if (mode == 2 && stall != 5) hold_ok = 1'b0;
    for (int i = 0; i < 16; i++) begin
      l1[127 - 8*i -: 8] = buffer[i];
      l2[127 - 8*i -: 8] = buffer[16 + i];
    end
  endtask

  function automatic logic [127:0] exp_l2(input int i);
`ifdef LCD_FMT_ZERO_BLANK_EN
    return vecs[i].l2zb;
`else
    return vecs[i].l2;
`endif
  endfunction

  initial begin
    logic [127:0] l1, l2;
    int  ntx, first_v, cyc;
    bit  seq_ok, done_ok, hold_ok;

    vecs[0] = '{4'd1,  4'd3,  16'd42,    "ADD     R03     ", "=+00042         ", "=+   42         "};
    vecs[1] = '{4'd3,  4'd15, 16'h8000,  "SUB     R15     ", "=-32768         ", "=-32768         "};
    vecs[2] = '{4'd0,  4'd9,  16'hFFFF,  "LOAD    R09     ", "=-00001         ", "=-    1         "};
    vecs[3] = '{4'hF,  4'd0,  16'd0,     "-       R00     ", "=+00000         ", "=+    0         "};
    vecs[4] = '{4'd7,  4'd10, 16'h7FFF,  "DISPLAY R10     ", "=+32767         ", "=+32767         "};
    vecs[5] = '{4'd6,  4'd12, 16'hFF9C,  "CLEAR   R12     ", "=-00100         ", "=-  100         "};
    vecs[6] = '{4'd2,  4'd1,  16'd12345, "ADDI    R01     ", "=+12345         ", "=+12345         "};
    vecs[7] = '{4'd5,  4'd5,  16'd5,     "MUL     R05     ", "=+00005         ", "=+    5         "};
    vecs[8] = '{4'd4,  4'd14, 16'd1000,  "SUBI    R14     ", "=+01000         ", "=+ 1000         "};

    reset = 1'b1; start = 1'b0; opcode = '0; dest_reg = '0; result = '0; char_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_valid", char_valid, 0);
    chk("rst_data",  char_data,  0);
    chk("rst_pos",   char_pos,   0);
    chk("rst_busy",  busy,       0);
    chk("rst_done",  done,       0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_ready_ignored", {char_valid, busy, done}, 0);

    // Back-to-back frames: each start lands in the previous frame's done cycle.
    for (int i = 0; i < 9; i++) begin
      run_frame(vecs[i].op, vecs[i].d, vecs[i].res, 0, l1, l2, ntx, seq_ok, first_v, done_ok, hold_ok);
      chk($sformatf("v%0d_line1", i), l1, vecs[i].l1);
      chk($sformatf("v%0d_line2", i), l2, exp_l2(i));
      chk($sformatf("v%0d_transfers", i), {seq_ok, 8'(ntx)}, {1'b1, 8'd32});
      chk($sformatf("v%0d_latency", i), 32'(first_v), 32'd17);
      chk($sformatf("v%0d_done", i), done_ok, 1);
    end

    // Second start and input changes while busy.
    run_frame(vecs[0].op, vecs[0].d, vecs[0].res, 1, l1, l2, ntx, seq_ok, first_v, done_ok, hold_ok);
    chk("busy_ign_line1", l1, vecs[0].l1);
    chk("busy_ign_line2", l2, exp_l2(0));
    chk("busy_ign_transfers", {seq_ok, 8'(ntx)}, {1'b1, 8'd32});
    chk("busy_ign_latency", 32'(first_v), 32'd17);
    @(negedge clk);
    chk("busy_ign_no_requeue", {busy, char_valid, done}, 0);

    // Back-pressure at position 9.
    run_frame(vecs[1].op, vecs[1].d, vecs[1].res, 2, l1, l2, ntx, seq_ok, first_v, done_ok, hold_ok);
    chk("stall_line1", l1, vecs[1].l1);
    chk("stall_line2", l2, exp_l2(1));
    chk("stall_transfers", {seq_ok, 8'(ntx)}, {1'b1, 8'd32});
    chk("stall_hold", hold_ok, 1);
    chk("stall_done", done_ok, 1);

    // Reset while presenting position 20, then a fresh frame.
    opcode = vecs[0].op; dest_reg = vecs[0].d; result = vecs[0].res; start = 1'b1; char_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(char_valid && char_pos == 5'd20) && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    chk("abort_reached_pos20", {char_valid, char_pos}, {1'b1, 5'd20});
    reset = 1'b1;
    @(negedge clk);
    chk("abort_state", {char_valid, busy, done}, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_no_done", {char_valid, busy, done}, 0);
    run_frame(vecs[4].op, vecs[4].d, vecs[4].res, 0, l1, l2, ntx, seq_ok, first_v, done_ok, hold_ok);
    chk("after_abort_line1", l1, vecs[4].l1);
    chk("after_abort_line2", l2, exp_l2(4));
    chk("after_abort_transfers", {seq_ok, 8'(ntx)}, {1'b1, 8'd32});
    chk("after_abort_latency", 32'(first_v), 32'd17);
    chk("after_abort_done", done_ok, 1);
    @(negedge clk);
    chk("done_one_cycle", done, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
